// File: rtl/ui_io_pkg.sv
// Shared definitions for the user-I/O controller.
// Holds the register select codes, CTRL bit positions, the dark-digit pattern
// and the seven-segment decoder shared by all HEX digits.
package ui_io_pkg;

  typedef enum logic [2:0] {
    UI_KEY   = 3'd0,
    UI_SW    = 3'd1,
    UI_LEDR  = 3'd2,
    UI_HEX   = 3'd3,
    UI_KSTAT = 3'd4,
    UI_SSTAT = 3'd5,
    UI_CTRL  = 3'd6,
    UI_HEXEN = 3'd7
  } reg_sel_e;

  localparam int CTRL_KIE = 0;
  localparam int CTRL_SIE = 1;

  localparam logic [6:0] HEX_BLANK = 7'h7F;

  // Active-low segments, bit 6 = g ... bit 0 = a.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ui_io_controller_debouncer.sv
// Single-bit input debouncer: 2-flop synchroniser followed by a stability counter.
// Latency: 2 sync edges + 2^DEBOUNCE_BITS-1 counting edges; no backpressure.
// Ports: clk/reset, din raw input, dout debounced value, rise/fall flag the edge
// on which dout is about to change (so status logic can set on that same edge).
module input_debouncer #(
  parameter int   DEBOUNCE_BITS = 15,
  parameter logic RST_VAL       = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  // The commit happens on the edge where the counter would reach all ones,
  // so a disagreement must persist 2^DEBOUNCE_BITS-1 edges to be accepted.
  localparam logic [DEBOUNCE_BITS-1:0] CNT_LAST =
    DEBOUNCE_BITS'((64'd1 << DEBOUNCE_BITS) - 64'd2);

  logic                     sync1, sync2, stable;
  logic [DEBOUNCE_BITS-1:0] cnt;
  logic                     commit;

  assign commit = (sync2 != stable) && (cnt == CNT_LAST);
  assign rise   = commit &  sync2;
  assign fall   = commit & ~sync2;
  assign dout   = stable;

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      sync1  <= RST_VAL;
      sync2  <= RST_VAL;
      stable <= RST_VAL;
      cnt    <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (commit) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ui_io_controller.sv
// Memory-mapped user-I/O block: debounced keys/switches, sticky W1C status, LEDs, HEX.
// Latency: writes land on the falling edge sel&wrtEn is sampled; reads combinational.
// Ports: bus (sel, wrtEn, regSel, in, out tri-stated when deselected), KEYS,
// SWITCHES, LED, HEX (7 bits per digit, active-low), irq level output.
module ui_io_controller
  import ui_io_pkg::*;
#(
  parameter int DBITS         = 32,
  parameter int NUM_KEYS      = 4,
  parameter int NUM_SW        = 10,
  parameter int NUM_LEDS      = 10,
  parameter int NUM_HEX       = 4,
  parameter int DEBOUNCE_BITS = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sel,
  input  logic                 wrtEn,
  input  logic [2:0]           regSel,
  input  logic [DBITS-1:0]     in,
  output logic [DBITS-1:0]     out,
  input  logic [NUM_KEYS-1:0]  KEYS,
  input  logic [NUM_SW-1:0]    SWITCHES,
  output logic [NUM_LEDS-1:0]  LED,
  output logic [7*NUM_HEX-1:0] HEX,
  output logic                 irq
);

  logic [NUM_KEYS-1:0]  key_db, key_fall, key_rise_unused;
  logic [NUM_SW-1:0]    sw_db, sw_rise, sw_fall;
  logic [NUM_LEDS-1:0]  led_reg;
  logic [4*NUM_HEX-1:0] hex_reg;
  logic [NUM_HEX-1:0]   hexen;
  logic [NUM_KEYS-1:0]  kstat;
  logic [NUM_SW-1:0]    sstat;
  logic                 kie, sie;
  logic                 wr;
  logic [NUM_KEYS-1:0]  kclr;
  logic [NUM_SW-1:0]    sclr;
  logic [DBITS-1:0]     rdata;
  logic                 in_unused;

  // Upper data bits are not stored by any register at default sizes.
  assign in_unused = ^in;

  // Keys idle high (released), so their debouncers reset to 1.
  input_debouncer #(.DEBOUNCE_BITS(DEBOUNCE_BITS), .RST_VAL(1'b1)) u_key_db [NUM_KEYS-1:0] (
    .clk  (clk),
    .reset(reset),
    .din  (KEYS),
    .dout (key_db),
    .rise (key_rise_unused),
    .fall (key_fall)
  );

  input_debouncer #(.DEBOUNCE_BITS(DEBOUNCE_BITS), .RST_VAL(1'b0)) u_sw_db [NUM_SW-1:0] (
    .clk  (clk),
    .reset(reset),
    .din  (SWITCHES),
    .dout (sw_db),
    .rise (sw_rise),
    .fall (sw_fall)
  );

  assign wr   = sel & wrtEn;
  assign kclr = (wr && regSel == UI_KSTAT) ? in[NUM_KEYS-1:0] : '0;
  assign sclr = (wr && regSel == UI_SSTAT) ? in[NUM_SW-1:0]   : '0;

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      led_reg <= '0;
      hex_reg <= '0;
      hexen   <= '1;
      kstat   <= '0;
      sstat   <= '0;
      kie     <= 1'b0;
      sie     <= 1'b0;
    end else begin
      if (wr && regSel == UI_LEDR)  led_reg <= in[NUM_LEDS-1:0];
      if (wr && regSel == UI_HEX)   hex_reg <= in[4*NUM_HEX-1:0];
      if (wr && regSel == UI_HEXEN) hexen   <= in[NUM_HEX-1:0];
      if (wr && regSel == UI_CTRL) begin
        kie <= in[CTRL_KIE];
        sie <= in[CTRL_SIE];
      end
      // OR-ing the new events in after the clear lets a set win over a same-edge W1C.
      kstat <= (kstat & ~kclr) | key_fall;
      sstat <= (sstat & ~sclr) | sw_rise | sw_fall;
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_sel_e'(regSel))
      UI_KEY:   rdata[NUM_KEYS-1:0] = key_db;
      UI_SW:    rdata[NUM_SW-1:0]   = sw_db;
      UI_LEDR:  rdata[NUM_LEDS-1:0] = led_reg;
      UI_HEX:   rdata[4*NUM_HEX-1:0] = hex_reg;
      UI_KSTAT: rdata[NUM_KEYS-1:0] = kstat;
      UI_SSTAT: rdata[NUM_SW-1:0]   = sstat;
      UI_CTRL: begin
        rdata[CTRL_KIE] = kie;
        rdata[CTRL_SIE] = sie;
      end
      default:  rdata[NUM_HEX-1:0]  = hexen;
    endcase
  end

  assign out = sel ? rdata : {DBITS{1'bz}};
  assign LED = led_reg;
  assign irq = ((|kstat) & kie) | ((|sstat) & sie);

  for (genvar i = 0; i < NUM_HEX; i++) begin : g_hex
    assign HEX[7*i +: 7] = hexen[i] ? seg7(hex_reg[4*i +: 4]) : HEX_BLANK;
  end

endmodule

// File: tb/tb_ui_io_controller.sv
// Directed bench for ui_io_controller with a short debounce counter.
// Inputs change just after the rising edge; the DUT acts on the falling edge.
module tb_ui_io_controller;

  logic        clk;
  logic        reset;
  logic        sel, wrtEn;
  logic [2:0]  regSel;
  logic [31:0] din;
  wire  [31:0] dout;
  logic [3:0]  keys;
  logic [9:0]  sw;
  logic [9:0]  led;
  logic [27:0] hex;
  logic        irq;

  int n_chk = 0;
  int n_bad = 0;
  logic [31:0] v;

  ui_io_controller #(
    .DBITS(32), .NUM_KEYS(4), .NUM_SW(10), .NUM_LEDS(10), .NUM_HEX(4), .DEBOUNCE_BITS(3)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .sel     (sel),
    .wrtEn   (wrtEn),
    .regSel  (regSel),
    .in      (din),
    .out     (dout),
    .KEYS    (keys),
    .SWITCHES(sw),
    .LED     (led),
    .HEX     (hex),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Advance past one falling edge and settle just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] r, input logic [31:0] d);
    sel = 1'b1; wrtEn = 1'b1; regSel = r; din = d;
    tick();
    sel = 1'b0; wrtEn = 1'b0; din = '0;
  endtask

  task automatic rd(input logic [2:0] r, output logic [31:0] d);
    sel = 1'b1; wrtEn = 1'b0; regSel = r;
    #1;
    d = dout;
    sel = 1'b0;
  endtask

  initial begin
    reset = 1'b0; sel = 1'b0; wrtEn = 1'b0; regSel = '0; din = '0;
    keys = 4'hF; sw = '0;
    repeat (2) tick();

    // Reset state
    chk("rst_led", led, 10'h000);
    chk("rst_hex", hex, {7'h40, 7'h40, 7'h40, 7'h40});
    chk("rst_irq", irq, 1'b0);
    reset = 1'b1;
    tick();
    rd(3'd0, v); chk("rst_key", v, 32'hF);
    rd(3'd7, v); chk("rst_hexen", v, 32'hF);
    rd(3'd4, v); chk("rst_kstat", v, 32'h0);

    // LED write, deselected write, RO write
    wr(3'd2, 32'h0000_03FF);
    chk("led_wr", led, 10'h3FF);
    rd(3'd2, v); chk("ledr_rd", v, 32'h0000_03FF);
    sel = 1'b0; wrtEn = 1'b1; regSel = 3'd2; din = 32'h0;
    tick();
    wrtEn = 1'b0;
    chk("led_nosel", led, 10'h3FF);
    wr(3'd0, 32'h0);
    rd(3'd0, v); chk("key_ro", v, 32'hF);

    // Short glitch on KEYS[2] is rejected
    keys[2] = 1'b0;
    repeat (4) tick();
    keys[2] = 1'b1;
    repeat (12) tick();
    rd(3'd0, v); chk("glitch_key", v, 32'hF);
    rd(3'd4, v); chk("glitch_kstat", v, 32'h0);

    // Held press of KEYS[2]
    keys[2] = 1'b0;
    repeat (12) tick();
    rd(3'd0, v); chk("press_key", v, 32'hB);
    rd(3'd4, v); chk("press_kstat", v, 32'h4);
    chk("press_irq_off", irq, 1'b0);
    wr(3'd6, 32'h1);
    chk("kie_irq", irq, 1'b1);
    wr(3'd4, 32'h4);
    rd(3'd4, v); chk("w1c_kstat", v, 32'h0);
    chk("w1c_irq", irq, 1'b0);
    keys[2] = 1'b1;
    repeat (12) tick();
    rd(3'd0, v); chk("release_key", v, 32'hF);
    rd(3'd4, v); chk("release_kstat", v, 32'h0);

    // W1C on the very edge KEYS[0] finishes debouncing: the set wins
    keys[0] = 1'b0;
    repeat (8) tick();
    rd(3'd0, v); chk("edge_key_pre", v, 32'hF);
    wr(3'd4, 32'h1);
    rd(3'd0, v); chk("edge_key_post", v, 32'hE);
    rd(3'd4, v); chk("edge_kstat", v, 32'h1);
    chk("edge_irq", irq, 1'b1);
    wr(3'd4, 32'h1);
    chk("edge_irq_clr", irq, 1'b0);
    keys[0] = 1'b1;
    repeat (12) tick();

    // HEX with per-digit blanking
    wr(3'd3, 32'h0000_BEEF);
    wr(3'd7, 32'h5);
    chk("hex_blank", hex, {7'h7F, 7'h06, 7'h7F, 7'h0E});
    rd(3'd3, v); chk("hex_rd", v, 32'h0000_BEEF);

    // CTRL only keeps its two bits
    wr(3'd6, 32'hFFFF_FFFF);
    rd(3'd6, v); chk("ctrl_rd", v, 32'h3);

    // Switch change with SIE
    wr(3'd6, 32'h2);
    sw[9] = 1'b1;
    repeat (12) tick();
    rd(3'd5, v); chk("sw9_sstat", v, 32'h200);
    rd(3'd1, v); chk("sw9_sw", v, 32'h200);
    chk("sw9_irq", irq, 1'b1);
    wr(3'd5, 32'h200);
    rd(3'd5, v); chk("sw9_clr", v, 32'h0);
    chk("sw9_irq_clr", irq, 1'b0);

    // Reset in the middle of SWITCHES[0] debounce
    sw[0] = 1'b1;
    repeat (5) tick();
    reset = 1'b0;
    #2;
    rd(3'd5, v); chk("midrst_sstat", v, 32'h0);
    rd(3'd1, v); chk("midrst_sw", v, 32'h0);
    rd(3'd6, v); chk("midrst_ctrl", v, 32'h0);
    chk("midrst_led", led, 10'h000);
    chk("midrst_irq", irq, 1'b0);
    tick();
    reset = 1'b1;
    tick();
    rd(3'd1, v); chk("postrst_sw_early", v, 32'h0);
    // Switches high through reset are reported once debounced
    repeat (12) tick();
    rd(3'd1, v); chk("postrst_sw", v, 32'h201);
    rd(3'd5, v); chk("postrst_sstat", v, 32'h201);
    chk("postrst_irq", irq, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
